ifetch: RTL
===========

# ifetch

Instruction fetch unit: the initiator that drives the word-aligned address port of the instruction memory and consumes its combinational read data. It keeps the program counter, issues one fetch per cycle when there is space, and buffers {pc, instruction} pairs in a 2-entry FIFO. The FIFO feeds decode over a valid/ready handshake. Redirects from execute (branch or jump) flush the buffer; a misaligned redirect target produces a single faulting entry.

## Interface
Parameters:
- WIDTH, 32, datapath and PC width
- RESET_PC, 32'h0000_0000, PC after reset; bits [1:0] are ignored and treated as 0

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; synchronous, active-high
- imem_addr_out  out  WIDTH-2  word address to instruction memory (PC[WIDTH-1:2])
- imem_data_in  in  WIDTH  instruction word for imem_addr_out, valid in the same cycle
- redirect_valid_in  in  1  load a new PC this cycle
- redirect_pc_in  in  WIDTH  redirect target byte address
- inst_valid_out  out  1  FIFO head is valid
- inst_ready_in  in  1  decode accepts the head (pop when valid & ready)
- inst_out  out  WIDTH  head instruction
- pc_out  out  WIDTH  head byte PC
- misaligned_out  out  1  head is a fault entry (inst_out = 32'h00000013)

## Operation
- State register: RUN, FAULT_PEND, HALT. Reset state is RUN.
- FIFO: 2 entries {pc, inst, fault}, with rd/wr pointers and a count from 0 to 2. The head drives the outputs directly.
- Pop: inst_valid_out & inst_ready_in & !redirect_valid_in.
- Fetch address is combinational: imem_addr_out = redirect_valid_in ? redirect_pc_in[WIDTH-1:2] : pc[WIDTH-1:2].
- Push, normal case: state == RUN, no redirect, and (count < 2 or pop). The entry is {pc, imem_data_in, 0}, and pc <= pc + 4.
- When the push condition is false in RUN, pc holds.
- PC arithmetic is modulo 2^WIDTH: 0xFFFF_FFFC + 4 = 0x0000_0000.
- Aligned redirect (redirect_pc_in[1:0] == 0), any state:
  - flush the FIFO (count <= 0; no pop this cycle);
  - push {redirect_pc_in, imem_data_in, 0};
  - pc <= redirect_pc_in + 4; state <= RUN.
- Misaligned redirect, any state:
  - flush, no push; pc <= redirect_pc_in; state <= FAULT_PEND.
- FAULT_PEND: push {pc, 32'h00000013, 1} (FIFO is empty), then state <= HALT.
- HALT: no pushes, pc holds. Pops continue normally. Only a redirect or reset leaves HALT.
- Redirect takes priority over pop and push. Reset takes priority over everything.
- Reset: FIFO cleared, pc <= RESET_PC, state <= RUN, no push.

## Timing
- Reset values: inst_valid_out 0, inst_out 0, pc_out 0, misaligned_out 0. imem_addr_out = RESET_PC[WIDTH-1:2] during reset.
- Fetch-to-output latency is 1 cycle: an entry pushed in cycle N is visible as the head in N+1.
- First valid after reset: rst deasserted in cycle 0, fetch of RESET_PC in cycle 0, inst_valid_out = 1 in cycle 1.
- Throughput is 1 instruction per cycle while inst_ready_in is held high.
- Full FIFO (count == 2) with no pop: no fetch, and the outputs and pc are stable.
- With count == 2, a simultaneous pop and push is allowed; the count stays at 2.
- Aligned redirect in cycle N: the head in N+1 is the target entry. Any fire in cycle N is discarded.
- Misaligned redirect in cycle N: inst_valid_out = 0 in N+1; the fault entry is valid from N+2 until it is accepted. inst_valid_out = 0 after that.
- The head and its outputs must remain stable while valid & !ready.
- Reset in the middle of a stream: the next cycle has inst_valid_out = 0 and the FIFO is empty.

## Test plan
- Reset with RESET_PC = 0x0, memory word i = i, ready held high:
  - inst_valid_out is 0 during reset;
  - cycles 1..4 give pc_out 0x0, 0x4, 0x8, 0xC and inst_out 0, 1, 2, 3, one per cycle.
- Backpressure, with ready low for 5 cycles after the first valid:
  - count saturates at 2 and the head holds pc 0x0;
  - pc stops advancing and imem_addr_out holds 2;
  - on releasing ready the sequence resumes 0x0, 0x4, 0x8 with no gaps or duplicates.
- Aligned redirect to 0x40 while the FIFO holds 2 entries and ready is high:
  - the next-cycle head is pc 0x40;
  - then 0x44, with no old entry ever delivered.
- Misaligned redirect to 0x42:
  - valid is 0 for one cycle;
  - then a single entry with pc 0x42, inst 0x00000013, misaligned 1;
  - then valid stays 0 for 10 cycles;
  - a redirect to 0x80 restarts delivery at 0x80.
- Wrap: redirect to 0xFFFF_FFF8 gives pc_out 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Reset asserted with 2 entries buffered and ready low:
  - the next cycle has valid 0;
  - after release the stream restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch.sv
// ifetch -- instruction fetch unit.
//
// Keeps the program counter, drives the word address of a combinational
// instruction memory and buffers {pc, instruction, fault} entries in a
// 2-entry FIFO that feeds decode.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   imem_addr_out       word address to instruction memory (PC[WIDTH-1:2])
//   imem_data_in        instruction word for imem_addr_out, same cycle
//   redirect_valid_in   load redirect_pc_in as the new PC this cycle
//   redirect_pc_in      redirect target byte address
//   inst_valid_out      FIFO head is valid
//   inst_ready_in       decode accepts the head
//   inst_out, pc_out    head instruction and its byte PC
//   misaligned_out      head is a fault entry (inst_out is a NOP)
//   fsm_state           current fetch state, for observation only
//
// Handshake: an entry moves to decode in any cycle where inst_valid_out and
// inst_ready_in are both high and no redirect is present. While valid is
// high and ready is low, the head and all its outputs hold steady.
module ifetch #(
  parameter int unsigned            WIDTH    = 32,
  parameter logic [WIDTH-1:0]       RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-3:0] imem_addr_out,
  input  logic [WIDTH-1:0] imem_data_in,
  input  logic             redirect_valid_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             inst_valid_out,
  input  logic             inst_ready_in,
  output logic [WIDTH-1:0] inst_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             misaligned_out,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    FAULT_PEND = 2'd1,
    HALT       = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] NOP_INST    = WIDTH'(32'h0000_0013);
  localparam logic [WIDTH-1:0] PC_STEP     = WIDTH'(4);
  // The low two bits of the reset PC are forced to zero.
  localparam logic [WIDTH-1:0] RESET_PC_AL = {RESET_PC[WIDTH-1:2], 2'b00};

  state_t           state, state_next;
  logic [WIDTH-1:0] pc, pc_next;

  logic [WIDTH-1:0] fifo_pc   [2];
  logic [WIDTH-1:0] fifo_inst [2];
  logic             fifo_fault[2];
  logic             rd_ptr, wr_ptr;
  logic [1:0]       count;

  logic             redirect_aligned;
  logic             pop;
  logic             push;
  logic [WIDTH-1:0] push_inst;
  logic             push_fault;

  // Next-state, PC and push decision. Redirects override everything else;
  // their FIFO effect (flush plus optional target entry) is applied in the
  // register process.
  always_comb begin
    redirect_aligned = (redirect_pc_in[1:0] == 2'b00);
    pop              = (count != 2'd0) && inst_ready_in && !redirect_valid_in;
    push             = 1'b0;
    push_inst        = imem_data_in;
    push_fault       = 1'b0;
    pc_next          = pc;
    state_next       = state;

    if (redirect_valid_in) begin
      if (redirect_aligned) begin
        pc_next    = redirect_pc_in + PC_STEP;
        state_next = RUN;
      end else begin
        pc_next    = redirect_pc_in;
        state_next = FAULT_PEND;
      end
    end else begin
      case (state)
        RUN: begin
          // A full FIFO may still accept a fetch when the head leaves.
          if ((count != 2'd2) || pop) begin
            push    = 1'b1;
            pc_next = pc + PC_STEP;
          end
        end
        FAULT_PEND: begin
          // FIFO was flushed by the misaligned redirect, so there is room.
          push       = 1'b1;
          push_inst  = NOP_INST;
          push_fault = 1'b1;
          state_next = HALT;
        end
        HALT: begin
          state_next = HALT;
        end
        default: begin
          state_next = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= RUN;
      pc     <= RESET_PC_AL;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_pc[i]    <= '0;
        fifo_inst[i]  <= '0;
        fifo_fault[i] <= 1'b0;
      end
    end else begin
      state <= state_next;
      pc    <= pc_next;
      if (redirect_valid_in) begin
        rd_ptr <= 1'b0;
        if (redirect_aligned) begin
          // Flush and refill slot 0 with the target fetched this cycle.
          fifo_pc[0]    <= redirect_pc_in;
          fifo_inst[0]  <= imem_data_in;
          fifo_fault[0] <= 1'b0;
          wr_ptr        <= 1'b1;
          count         <= 2'd1;
        end else begin
          wr_ptr <= 1'b0;
          count  <= 2'd0;
        end
      end else begin
        if (push) begin
          fifo_pc[wr_ptr]    <= pc;
          fifo_inst[wr_ptr]  <= push_inst;
          fifo_fault[wr_ptr] <= push_fault;
          wr_ptr             <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

  // The fetch address follows a redirect in the same cycle so the target
  // word can be captured immediately.
  always_comb begin
    if (rst) begin
      imem_addr_out = RESET_PC[WIDTH-1:2];
    end else if (redirect_valid_in) begin
      imem_addr_out = redirect_pc_in[WIDTH-1:2];
    end else begin
      imem_addr_out = pc[WIDTH-1:2];
    end
  end

  assign inst_valid_out = (count != 2'd0);
  assign inst_out       = fifo_inst[rd_ptr];
  assign pc_out         = fifo_pc[rd_ptr];
  assign misaligned_out = fifo_fault[rd_ptr];
  assign fsm_state      = state;

endmodule
